// File: rtl/glyph_pkg.sv
// Shared constants and configuration record for the glyph fetch stage.
// The visible-area sizes are used by benches and the timing controller.
package glyph_pkg;

    localparam int DATA_WIDTH = 24;
    localparam int W_LOG2     = 4;
    localparam int H_LOG2     = 4;
    localparam int IDX_W      = 4;
    localparam int COORD_W    = 10;
    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [IDX_W-1:0]   idx;
        logic               en;
    } glyph_cfg_t;

endpackage

// File: rtl/glyph_fetch_if.sv
// Beam, configuration, glyph-ROM and pixel signals of the glyph fetch stage.
// master = timing controller / ROM side, slave = glyph_fetch.
interface glyph_fetch_if #(
    parameter int DATA_WIDTH = 24,
    parameter int IDX_W      = 4,
    parameter int ADDR_W     = 12
);
    logic                  bright_in;
    logic [9:0]            hcount;
    logic [9:0]            vcount;
    logic                  frame_start;
    logic                  cfg_we;
    logic [9:0]            cfg_x;
    logic [9:0]            cfg_y;
    logic [IDX_W-1:0]      cfg_idx;
    logic                  cfg_en;
    logic [ADDR_W-1:0]     rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  pix_en;
    logic                  bright;

    modport master (
        output bright_in, hcount, vcount, frame_start,
        output cfg_we, cfg_x, cfg_y, cfg_idx, cfg_en, rom_data,
        input  rom_addr, pixel, pix_en, bright
    );

    modport slave (
        input  bright_in, hcount, vcount, frame_start,
        input  cfg_we, cfg_x, cfg_y, cfg_idx, cfg_en, rom_data,
        output rom_addr, pixel, pix_en, bright
    );
endinterface

// File: rtl/glyph_cfg_shadow.sv
// Pending/active glyph configuration pair; pending moves to active on frame_start.
// A write coinciding with frame_start lands in both registers at once.
module glyph_cfg_shadow
    import glyph_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic       frame_start,
    input  glyph_cfg_t cfg_in,
    output glyph_cfg_t active
);

    glyph_cfg_t pending_reg;
    glyph_cfg_t active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            active_reg  <= '0;
        end else begin
            if (cfg_we) begin
                pending_reg <= cfg_in;
            end
            if (frame_start) begin
                active_reg <= cfg_we ? cfg_in : pending_reg;
            end
        end
    end

    assign active = active_reg;

endmodule

// File: rtl/glyph_fetch.sv
// Three-stage glyph texel fetch: box test + ROM address, ROM read, output align.
// Beam inputs reach pixel/pix_en/bright exactly three clocks later.
module glyph_fetch #(
    parameter int DATA_WIDTH = glyph_pkg::DATA_WIDTH,
    parameter int W_LOG2     = glyph_pkg::W_LOG2,
    parameter int H_LOG2     = glyph_pkg::H_LOG2,
    parameter int IDX_W      = glyph_pkg::IDX_W,
    parameter int ADDR_W     = IDX_W + H_LOG2 + W_LOG2
) (
    input logic          clk,
    input logic          rst_n,
    glyph_fetch_if.slave bus
);
    import glyph_pkg::*;

    localparam int GW = 1 << W_LOG2;
    localparam int GH = 1 << H_LOG2;

    glyph_cfg_t cfg_in;
    glyph_cfg_t active;

    assign cfg_in = '{x: bus.cfg_x, y: bus.cfg_y, idx: bus.cfg_idx, en: bus.cfg_en};

    glyph_cfg_shadow u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (bus.cfg_we),
        .frame_start (bus.frame_start),
        .cfg_in      (cfg_in),
        .active      (active)
    );

    // 11-bit bounds so a box near column/row 1023 clips instead of wrapping to 0.
    logic [10:0] h_ext, v_ext, x_lo, x_hi, y_lo, y_hi;
    assign h_ext = {1'b0, bus.hcount};
    assign v_ext = {1'b0, bus.vcount};
    assign x_lo  = {1'b0, active.x};
    assign y_lo  = {1'b0, active.y};
    assign x_hi  = x_lo + 11'(GW);
    assign y_hi  = y_lo + 11'(GH);

    logic in_box;
    assign in_box = active.en & bus.bright_in
                  & (h_ext >= x_lo) & (h_ext < x_hi)
                  & (v_ext >= y_lo) & (v_ext < y_hi);

    // Low bits of the offset depend only on the low bits of the operands.
    logic [W_LOG2-1:0] dx;
    logic [H_LOG2-1:0] dy;
    assign dx = bus.hcount[W_LOG2-1:0] - active.x[W_LOG2-1:0];
    assign dy = bus.vcount[H_LOG2-1:0] - active.y[H_LOG2-1:0];

    logic [ADDR_W-1:0]     rom_addr_reg;
    logic                  in_box_1_reg, bright_1_reg;
    logic                  in_box_2_reg, bright_2_reg;
    logic [DATA_WIDTH-1:0] pixel_reg;
    logic                  pix_en_reg, bright_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
            in_box_1_reg <= 1'b0;
            bright_1_reg <= 1'b0;
            in_box_2_reg <= 1'b0;
            bright_2_reg <= 1'b0;
            pixel_reg    <= '0;
            pix_en_reg   <= 1'b0;
            bright_reg   <= 1'b0;
        end else begin
            if (in_box) begin
                rom_addr_reg <= {active.idx, dy, dx};
            end
            in_box_1_reg <= in_box;
            bright_1_reg <= bus.bright_in;
            in_box_2_reg <= in_box_1_reg;
            bright_2_reg <= bright_1_reg;
            pixel_reg    <= in_box_2_reg ? bus.rom_data : '0;
            pix_en_reg   <= in_box_2_reg;
            bright_reg   <= bright_2_reg;
        end
    end

    assign bus.rom_addr = rom_addr_reg;
    assign bus.pixel    = pixel_reg;
    assign bus.pix_en   = pix_en_reg;
    assign bus.bright   = bright_reg;

endmodule

// File: tb/tb_glyph_fetch.sv
// Bench for glyph_fetch: ROM model returns its address as data, a queue
// scoreboard checks every output triple three clocks after it was driven.
module tb_glyph_fetch;
    import glyph_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glyph_fetch_if bus ();

    glyph_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous ROM whose word equals its zero-extended address.
    always @(posedge clk) bus.rom_data <= {12'h000, bus.rom_addr};

    typedef struct {
        logic [25:0] exp;
        int          h;
        int          v;
    } sb_t;

    typedef struct {
        int          h;
        int          v;
        logic        b;
        logic [25:0] exp;
    } vec_t;

    sb_t        sbq[$];
    int         total = 0;
    int         bad = 0;
    int         row_cnt[1024];
    glyph_cfg_t cfg_v;
    glyph_cfg_t m_pend;
    glyph_cfg_t m_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] model(input int h, input int v, input logic b, input glyph_cfg_t a);
        int          dx;
        int          dy;
        logic        inb;
        logic [23:0] p;
        dx  = h - int'(a.x);
        dy  = v - int'(a.y);
        inb = a.en && b && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
        p   = inb ? 24'(int'(a.idx) * 256 + dy * 16 + dx) : 24'h0;
        return {p, inb, b};
    endfunction

    // One pixel clock: retire the oldest entry, drive new inputs, push expectation.
    task automatic step(input int h, input int v, input logic b, input logic fs,
                        input logic we, input logic use_tab, input logic [25:0] tab_exp);
        sb_t e;
        @(negedge clk);
        if (sbq.size() >= 3) begin
            e = sbq.pop_front();
            total++;
            if ({bus.pixel, bus.pix_en, bus.bright} !== e.exp) begin
                bad++;
                $display("FAIL sb h=%0d v=%0d got=%h expected=%h",
                         e.h, e.v, {bus.pixel, bus.pix_en, bus.bright}, e.exp);
            end
            if (bus.pix_en === 1'b1) row_cnt[e.v]++;
        end
        bus.hcount      = 10'(h);
        bus.vcount      = 10'(v);
        bus.bright_in   = b;
        bus.frame_start = fs;
        bus.cfg_we      = we;
        bus.cfg_x       = cfg_v.x;
        bus.cfg_y       = cfg_v.y;
        bus.cfg_idx     = cfg_v.idx;
        bus.cfg_en      = cfg_v.en;
        e.exp = use_tab ? tab_exp : model(h, v, b, m_act);
        e.h   = h;
        e.v   = v;
        sbq.push_back(e);
        if (fs) m_act = we ? cfg_v : m_pend;
        if (we) m_pend = cfg_v;
    endtask

    task automatic idle(input logic fs, input logic we);
        step(0, 0, 1'b0, fs, we, 1'b0, 26'h0);
    endtask

    task automatic drain();
        repeat (3) idle(1'b0, 1'b0);
    endtask

    task automatic scan(input int v0, input int v1, input int h0, input int h1);
        foreach (row_cnt[i]) row_cnt[i] = 0;
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++)
                step(h, v, (h < H_VISIBLE) && (v < V_VISIBLE), 1'b0, 1'b0, 1'b0, 26'h0);
        drain();
    endtask

    task automatic check_rows(input int v0, input int v1, input int ylo, input int yhi, input int n);
        for (int v = v0; v <= v1; v++)
            check($sformatf("row_count v=%0d", v), 32'(row_cnt[v]),
                  32'((v >= ylo && v <= yhi) ? n : 0));
    endtask

    task automatic run_table(input vec_t tab[]);
        foreach (tab[i]) begin
            $display("vec %0d: h=%0d v=%0d bright_in=%0b expect pixel=%h pix_en=%0b bright=%0b",
                     i, tab[i].h, tab[i].v, tab[i].b, tab[i].exp[25:2], tab[i].exp[1], tab[i].exp[0]);
            step(tab[i].h, tab[i].v, tab[i].b, 1'b0, 1'b0, 1'b1, tab[i].exp);
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t box_tab[];
        vec_t clip_tab[];

        box_tab = new[10];
        box_tab[0] = '{100, 50, 1'b1, {24'h000300, 1'b1, 1'b1}};
        box_tab[1] = '{115, 50, 1'b1, {24'h00030F, 1'b1, 1'b1}};
        box_tab[2] = '{116, 50, 1'b1, {24'h000000, 1'b0, 1'b1}};
        box_tab[3] = '{99,  50, 1'b1, {24'h000000, 1'b0, 1'b1}};
        box_tab[4] = '{100, 65, 1'b1, {24'h0003F0, 1'b1, 1'b1}};
        box_tab[5] = '{115, 65, 1'b1, {24'h0003FF, 1'b1, 1'b1}};
        box_tab[6] = '{100, 66, 1'b1, {24'h000000, 1'b0, 1'b1}};
        box_tab[7] = '{100, 49, 1'b1, {24'h000000, 1'b0, 1'b1}};
        box_tab[8] = '{107, 52, 1'b0, {24'h000000, 1'b0, 1'b0}};
        box_tab[9] = '{103, 55, 1'b1, {24'h000353, 1'b1, 1'b1}};

        clip_tab = new[6];
        clip_tab[0] = '{1023, 470, 1'b1, {24'h000503, 1'b1, 1'b1}};
        clip_tab[1] = '{1020, 479, 1'b1, {24'h000590, 1'b1, 1'b1}};
        clip_tab[2] = '{0,    470, 1'b1, {24'h000000, 1'b0, 1'b1}};
        clip_tab[3] = '{11,   475, 1'b1, {24'h000000, 1'b0, 1'b1}};
        clip_tab[4] = '{1019, 470, 1'b1, {24'h000000, 1'b0, 1'b1}};
        clip_tab[5] = '{1023, 479, 1'b0, {24'h000000, 1'b0, 1'b0}};

        bus.hcount = '0; bus.vcount = '0; bus.bright_in = 1'b0;
        bus.frame_start = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
        cfg_v = '0; m_pend = '0; m_act = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_pixel", 32'(bus.pixel), 32'h0);
        check("reset_pix_en", 32'(bus.pix_en), 32'h0);
        check("reset_bright", 32'(bus.bright), 32'h0);
        check("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
        rst_n = 1'b1;

        // frame_start with no configuration: nothing drawn, bright still delayed
        idle(1'b1, 1'b0);
        scan(48, 52, 95, 120);
        check_rows(48, 52, 0, -1, 0);

        // Glyph 3 at (100,50)
        cfg_v = '{x: 10'd100, y: 10'd50, idx: 4'd3, en: 1'b1};
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b0);
        run_table(box_tab);
        scan(49, 66, 96, 120);
        check_rows(49, 66, 50, 65, 16);

        // Mid-frame write must not move the glyph until the next frame_start
        cfg_v.x = 10'd200;
        idle(1'b0, 1'b1);
        scan(49, 52, 96, 220);
        check_rows(49, 52, 50, 65, 16);
        check("midframe_col200", 32'(row_cnt[50]), 32'd16);
        idle(1'b1, 1'b0);
        scan(49, 52, 96, 220);
        check_rows(49, 52, 50, 65, 16);

        // Write and frame_start together: newest values win
        cfg_v.x = 10'd300;
        idle(1'b1, 1'b1);
        scan(50, 51, 296, 320);
        check_rows(50, 51, 50, 65, 16);

        // Glyph near the bottom-right corner clips, never wraps to column 0
        cfg_v = '{x: 10'd1020, y: 10'd470, idx: 4'd5, en: 1'b1};
        idle(1'b1, 1'b1);
        run_table(clip_tab);
        scan(469, 481, 1015, 1023);
        check_rows(469, 481, 0, -1, 0);
        scan(469, 481, 0, 15);
        check_rows(469, 481, 0, -1, 0);

        // Reset while a glyph pixel is on the output
        cfg_v = '{x: 10'd100, y: 10'd50, idx: 4'd3, en: 1'b1};
        idle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(100 + i, 50, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0);
        #1;
        check("pre_reset_pix_en", 32'(bus.pix_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pix_en", 32'(bus.pix_en), 32'h0);
        check("async_reset_pixel", 32'(bus.pixel), 32'h0);
        check("async_reset_bright", 32'(bus.bright), 32'h0);
        sbq.delete();
        m_pend = '0;
        m_act  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // After release: nothing until cfg_we then frame_start
        foreach (row_cnt[i]) row_cnt[i] = 0;
        for (int i = 0; i < 16; i++) step(100 + i, 50, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(100 + i, 51, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0);
        idle(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(100 + i, 52, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0);
        drain();
        check_rows(50, 52, 52, 52, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
